// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pkg                                                                  |
// | Shared seven-segment decode table and polarity/width helpers.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seg_pkg;

    // Active-high {g,f,e,d,c,b,a} patterns for hex 0..F.
    localparam logic [6:0] HEX7SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] SEG_OFF(input logic active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    // Wide enough for the largest digit count; callers slice to DIGITS.
    function automatic logic [15:0] AN_OFF(input logic active_low);
        return active_low ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic int calc_ch_w(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex7seg                                                                  |
// | Combinational nibble to active-high seven-segment decode.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7SEG[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_mux                                                             |
// | Channel-selectable, frame-latched multiplexed seven-segment scanner.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter  int DIGITS     = 8,
    parameter  int CH         = 8,
    parameter  int SCAN_DIV   = 100000,
    parameter  int BLANK_CYC  = 2,
    parameter  int ACTIVE_LOW = 1,
    localparam int CH_W       = calc_ch_w(CH)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CH*DIGITS*4-1:0] ch_data,
    input  logic [CH_W-1:0]        ch_sel,
    input  logic                   freeze,
    input  logic                   blank_lz,
    input  logic [DIGITS-1:0]      dp_mask,
    output logic [DIGITS-1:0]      AN,
    output logic [7:0]             SEG,
    output logic                   frame_done
);

    localparam int              c_dw          = DIGITS * 4;
    localparam int              c_pre_w       = $clog2(SCAN_DIV);
    localparam int              c_dig_w       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic            c_pol         = (ACTIVE_LOW != 0);
    localparam logic [7:0]      c_seg_off     = SEG_OFF(c_pol);
    localparam logic [15:0]     c_an_off_full = AN_OFF(c_pol);
    localparam logic [DIGITS-1:0] c_an_off    = c_an_off_full[DIGITS-1:0];

    logic [c_pre_w-1:0] r_pre;
    logic [c_dig_w-1:0] r_dig;
    logic [c_dw-1:0]    r_snap;
    logic               r_load_pend;
    logic [DIGITS-1:0]  r_an;
    logic [7:0]         r_seg;
    logic               r_frame_done;

    logic               w_tick;
    logic               w_wrap;
    logic [c_dw-1:0]    w_sel_data;
    logic [DIGITS-1:0]  w_lz_off;
    logic [3:0]         w_nib;
    logic [6:0]         w_hex;
    logic               w_lit;
    logic [DIGITS-1:0]  w_an_hi;
    logic [7:0]         w_seg_hi;

    assign w_tick = (r_pre == c_pre_w'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_dig == c_dig_w'(DIGITS - 1));

    // Out-of-range selects fall through to all-zero data.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (ch_sel == CH_W'(k)) begin
                w_sel_data = ch_data[k*c_dw +: c_dw];
            end
        end
    end

    // Walk from the most significant digit down, tracking "all zero so far".
    always_comb begin
        logic w_zero_above;
        w_zero_above = 1'b1;
        w_lz_off     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_snap[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_lz_off[i] = blank_lz & w_zero_above;
            end
        end
    end

    assign w_nib = r_snap[4*int'(r_dig) +: 4];

    hex7seg u_hex7seg (
        .nibble (w_nib),
        .seg    (w_hex)
    );

    assign w_lit    = (r_pre >= c_pre_w'(BLANK_CYC)) && !w_lz_off[r_dig];
    assign w_seg_hi = w_lit ? {dp_mask[r_dig], w_hex} : 8'h00;

    always_comb begin
        w_an_hi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_an_hi[i] = w_lit && (r_dig == c_dig_w'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre       <= '0;
            r_dig       <= '0;
            r_snap      <= '0;
            r_load_pend <= 1'b1;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_dig <= (r_dig == c_dig_w'(DIGITS - 1)) ? '0 : r_dig + 1'b1;
            end
            // First edge after reset always loads so the display never shows stale zeros.
            if (r_load_pend || (w_wrap && !freeze)) begin
                r_snap <= w_sel_data;
            end
            r_load_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= c_an_off;
            r_seg        <= c_seg_off;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_hi ^ {DIGITS{c_pol}};
            r_seg        <= w_seg_hi ^ {8{c_pol}};
            r_frame_done <= w_wrap;
        end
    end

    assign AN         = r_an;
    assign SEG        = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
